// File: rtl/drum_pkg.sv
// Shared constants and helpers for the drum sequencer datapath.
package drum_pkg;

    localparam int unsigned NUM_INS           = 4;
    localparam int unsigned NUM_STEPS         = 8;
    localparam int unsigned BPM_W             = 8;
    localparam int unsigned BPM_DEFAULT       = 120;
    localparam int unsigned BPM_ZERO_FALLBACK = 60;
    localparam int unsigned ACC_W             = 33;

    // Tempo threshold: eighth notes at INC = 2*bpm means THRESH = 60*CLK_HZ.
    function automatic logic [ACC_W-1:0] calc_thresh(input int unsigned clk_hz);
        return ACC_W'(64'(clk_hz) * 64'd60);
    endfunction

endpackage

// File: rtl/drum_pattern_datapath_tempo_nco.sv
// Tempo NCO: phase accumulator producing one beat_tick per eighth note.
module tempo_nco
    import drum_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BPM_W-1:0] bpm,
    input  logic             play,
    output logic             beat_tick
);

    localparam logic [ACC_W-1:0] THRESH = calc_thresh(CLK_HZ);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] inc;
    logic             at_thresh;

    // Tick comes straight off the accumulator so the first play cycle ticks.
    always_comb begin
        inc       = ACC_W'({bpm, 1'b0});
        at_thresh = (acc_q >= THRESH);
        beat_tick = 1'b0;
        acc_d     = THRESH;
        if (play && !reset) begin
            beat_tick = at_thresh;
            acc_d     = at_thresh ? (acc_q - THRESH + inc) : (acc_q + inc);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= THRESH;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/drum_pattern_datapath.sv
// Drum sequencer datapath: pattern/BPM storage, tempo tick and per-instrument gates.
// Optional per-instrument trigger mute is enabled with DRUM_MUTE_EN.
module drum_pattern_datapath
    import drum_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned GATE_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BPM_W-1:0]     data_in,
    input  logic                 ld_ins1,
    input  logic                 ld_ins2,
    input  logic                 ld_ins3,
    input  logic                 ld_ins4,
    input  logic                 ld_bpm,
    input  logic                 play,
    input  logic [2:0]           timing,
`ifdef DRUM_MUTE_EN
    input  logic [NUM_INS-1:0]   mute,
`endif
    output logic                 beat_tick,
    output logic [NUM_INS-1:0]   gate,
    output logic                 bpm_err
);

    localparam int unsigned      CNT_W     = $clog2(GATE_CYCLES + 1);
    localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(GATE_CYCLES);

    logic [NUM_INS-1:0]   ld;
    logic [NUM_STEPS-1:0] pat_q [NUM_INS];
    logic [NUM_STEPS-1:0] pat_d [NUM_INS];
    logic [CNT_W-1:0]     cnt_q [NUM_INS];
    logic [CNT_W-1:0]     cnt_d [NUM_INS];
    logic [BPM_W-1:0]     bpm_q, bpm_d;
    logic                 bpm_err_q, bpm_err_d;
    logic                 tick_dly_q, tick_dly_d;
    logic [NUM_INS-1:0]   gate_q, gate_d;
    logic [NUM_INS-1:0]   trig;
    logic [NUM_INS-1:0]   mute_eff;

    assign ld = {ld_ins4, ld_ins3, ld_ins2, ld_ins1};

`ifdef DRUM_MUTE_EN
    logic [NUM_INS-1:0] mute_q, mute_d;
    assign mute_d   = mute;
    assign mute_eff = mute_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mute_q <= '0;
        end else begin
            mute_q <= mute_d;
        end
    end
`else
    assign mute_eff = '0;
`endif

    tempo_nco #(
        .CLK_HZ(CLK_HZ)
    ) u_nco (
        .clk       (clk),
        .reset     (reset),
        .bpm       (bpm_q),
        .play      (play),
        .beat_tick (beat_tick)
    );

    // Triggers use the pre-load pattern; the tick is delayed so timing has settled.
    always_comb begin
        bpm_d      = bpm_q;
        bpm_err_d  = bpm_err_q;
        tick_dly_d = beat_tick;
        trig       = '0;
        gate_d     = '0;
        for (int k = 0; k < NUM_INS; k++) begin
            pat_d[k] = ld[k] ? data_in : pat_q[k];
            trig[k]  = tick_dly_q & play & pat_q[k][timing] & ~mute_eff[k];
            if (trig[k]) begin
                cnt_d[k] = GATE_LOAD;
            end else if (cnt_q[k] != '0) begin
                cnt_d[k] = cnt_q[k] - CNT_W'(1);
            end else begin
                cnt_d[k] = cnt_q[k];
            end
            gate_d[k] = (cnt_d[k] != '0);
        end
        if (ld_bpm) begin
            if (data_in != '0) begin
                bpm_d     = data_in;
                bpm_err_d = 1'b0;
            end else begin
                bpm_d     = BPM_W'(BPM_ZERO_FALLBACK);
                bpm_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_INS; k++) begin
                pat_q[k] <= '0;
                cnt_q[k] <= '0;
            end
            bpm_q      <= BPM_W'(BPM_DEFAULT);
            bpm_err_q  <= 1'b0;
            tick_dly_q <= 1'b0;
            gate_q     <= '0;
        end else begin
            for (int k = 0; k < NUM_INS; k++) begin
                pat_q[k] <= pat_d[k];
                cnt_q[k] <= cnt_d[k];
            end
            bpm_q      <= bpm_d;
            bpm_err_q  <= bpm_err_d;
            tick_dly_q <= tick_dly_d;
            gate_q     <= gate_d;
        end
    end

    assign gate    = gate_q;
    assign bpm_err = bpm_err_q;

endmodule

// File: tb/tb_drum_pattern_datapath.sv
// Directed bench for drum_pattern_datapath (CLK_HZ=8, GATE_CYCLES=3).
module tb_drum_pattern_datapath;

    localparam int unsigned CLK_HZ = 8;
    localparam int unsigned GATE   = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = '0;
    logic       ld_ins1 = 1'b0, ld_ins2 = 1'b0, ld_ins3 = 1'b0, ld_ins4 = 1'b0;
    logic       ld_bpm = 1'b0;
    logic       play = 1'b0;
    logic [2:0] timing = 3'd7;
`ifdef DRUM_MUTE_EN
    logic [3:0] mute = '0;
`endif
    logic       beat_tick;
    logic [3:0] gate;
    logic       bpm_err;

    int total = 0;
    int bad   = 0;

    drum_pattern_datapath #(
        .CLK_HZ      (CLK_HZ),
        .GATE_CYCLES (GATE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .ld_ins1   (ld_ins1),
        .ld_ins2   (ld_ins2),
        .ld_ins3   (ld_ins3),
        .ld_ins4   (ld_ins4),
        .ld_bpm    (ld_bpm),
        .play      (play),
        .timing    (timing),
`ifdef DRUM_MUTE_EN
        .mute      (mute),
`endif
        .beat_tick (beat_tick),
        .gate      (gate),
        .bpm_err   (bpm_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] exp90;
        logic [11:0] exp_g0;
        logic        t;
        exp90  = 12'b1001_0100_1001;
        exp_g0 = 12'b0001_1101_1100;

        // Reset held with play high
        play = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("rst_gate", gate, 4'h0);
        check("rst_tick", beat_tick, 1'b0);
        check("rst_err", bpm_err, 1'b0);
        check("rst_bpm", dut.bpm_q, 8'd120);
        step();
        reset = 1'b0;
        play  = 1'b0;
        step();
        @(negedge clk);
        check("idle_acc", dut.u_nco.acc_q, 33'd480);
        step();

        // NCO at 120 bpm: tick every other cycle
        play = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("nco120_c%0d", i), beat_tick, (i % 2 == 0) ? 1'b1 : 1'b0);
            step();
        end
        play = 1'b0;
        step();

        // NCO at 90 bpm: intervals 3,3,2
        data_in = 8'd90;
        ld_bpm  = 1'b1;
        step();
        ld_bpm = 1'b0;
        step();
        play = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("nco90_c%0d", i), beat_tick, exp90[i]);
            step();
        end
        play = 1'b0;
        step();

        // BPM zero fallback, then recovery
        data_in = 8'd0;
        ld_bpm  = 1'b1;
        step();
        ld_bpm = 1'b0;
        @(negedge clk);
        check("bpm0_err", bpm_err, 1'b1);
        check("bpm0_val", dut.bpm_q, 8'd60);
        step();
        data_in = 8'd100;
        ld_bpm  = 1'b1;
        step();
        ld_bpm = 1'b0;
        @(negedge clk);
        check("bpm100_err", bpm_err, 1'b0);
        check("bpm100_val", dut.bpm_q, 8'd100);
        step();
        data_in = 8'd120;
        ld_bpm  = 1'b1;
        step();
        ld_bpm = 1'b0;

        // Trigger: pat1 = steps 0 and 2, FSM model advances timing on ticks
        data_in = 8'b0000_0101;
        ld_ins1 = 1'b1;
        step();
        ld_ins1 = 1'b0;
        timing  = 3'd7;
        play    = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("trig_c%0d", i), gate, {3'b000, exp_g0[i]});
            t = beat_tick;
            step();
            if (t) timing = timing + 3'd1;
        end
        play = 1'b0;
        repeat (4) step();

        // Retrigger: pat2 all steps, gate longer than tick period
        data_in = 8'h00;
        ld_ins1 = 1'b1;
        step();
        ld_ins1 = 1'b0;
        data_in = 8'hFF;
        ld_ins2 = 1'b1;
        step();
        ld_ins2 = 1'b0;
        timing  = 3'd7;
        play    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("retrig_c%0d", i), gate[1], (i >= 2) ? 1'b1 : 1'b0);
            t = beat_tick;
            step();
            if (t) timing = timing + 3'd1;
        end
        play = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check($sformatf("stop_c%0d", j), gate[1], (j < 3) ? 1'b1 : 1'b0);
            if (j == 1) check("stop_acc", dut.u_nco.acc_q, 33'd480);
            step();
        end

        // Reset mid-play clears running gates on the same edge
        play = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("pre_rst_gate", gate[1], 1'b1);
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        check("midrst_gate", gate, 4'h0);
        check("midrst_tick", beat_tick, 1'b0);
        step();
        reset = 1'b0;
        play  = 1'b0;
        step();

`ifdef DRUM_MUTE_EN
        // Mute suppresses triggers but never cuts a running gate
        data_in = 8'hFF;
        ld_ins1 = 1'b1;
        ld_ins3 = 1'b1;
        mute    = 4'b0100;
        step();
        ld_ins1 = 1'b0;
        ld_ins3 = 1'b0;
        step();
        timing = 3'd7;
        play   = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("mute_c3", gate, 4'b0001);
        step();
        mute = 4'b0101;
        play = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check($sformatf("mute_run_c%0d", j), gate, (j < 3) ? 4'b0001 : 4'b0000);
            step();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
